// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
// Holds the FSM encoding and the default sizing constants.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: first set bit of i_req at or after
// i_start, wrapping around; one-hot result plus a valid flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_gnt,
    output logic          o_valid
);

    int w_idx;

    // Walk the ring from the start index and keep the first hit.
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_start) + k) % N;
            if (!o_valid && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Write arbiter in front of a sync FIFO: round-robin between requesters.
// Define FIFO_ARB_BURST_EN to let an owner keep up to BURST_LEN grants.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int BURST_LEN = 4,
    parameter int IW        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_wdata,
    output logic [IW-1:0]            owner
);

    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      w_owner_nx;
    logic [IW-1:0]      w_start;
    logic [IW-1:0]      w_pick_idx;
    logic [NUM_REQ-1:0] w_rr_gnt;
    logic               w_rr_valid;
    logic [NUM_REQ-1:0] w_gnt;
    logic [WIDTH-1:0]   w_wdata;

    assign w_start = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .i_req   (req),
        .i_start (w_start),
        .o_gnt   (w_rr_gnt),
        .o_valid (w_rr_valid)
    );

    // Convert the one-hot round-robin winner to an index.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rr_gnt[i]) w_pick_idx = IW'(i);
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN + 1);

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          w_burst_ok;

    assign w_burst_ok = (r_state == BURST) && req[r_owner] &&
                        (r_cnt < CW'(BURST_LEN));

    // Next state: continue the burst, else fall back to round-robin.
    always_comb begin
        w_gnt      = '0;
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_owner_nx = r_owner;
        if (!fifo_full) begin
            if (w_burst_ok) begin
                w_gnt[r_owner] = 1'b1;
                w_cnt_nx       = r_cnt + 1'b1;
            end else if (w_rr_valid) begin
                w_gnt      = w_rr_gnt;
                w_owner_nx = w_pick_idx;
                w_cnt_nx   = CW'(1);
                w_state_nx = (BURST_LEN > 1) ? BURST : IDLE;
            end else begin
                w_state_nx = IDLE;
            end
        end
    end

    // State, counter and owner registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= IW'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_owner <= w_owner_nx;
        end
    end
`else
    // Pure round-robin: one word per owner turn.
    always_comb begin
        w_gnt      = '0;
        w_owner_nx = r_owner;
        if (!fifo_full && w_rr_valid) begin
            w_gnt      = w_rr_gnt;
            w_owner_nx = w_pick_idx;
        end
    end

    // Owner register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_owner <= IW'(NUM_REQ - 1);
        end else begin
            r_owner <= w_owner_nx;
        end
    end
`endif

    // Reset gates the grant so nothing leaks out while res is low.
    assign gnt        = w_gnt & {NUM_REQ{res}};
    assign fifo_wr_en = |gnt;
    assign owner      = r_owner;

    // Mux the granted requester's slice onto the FIFO data bus.
    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) w_wdata |= req_data[i*WIDTH +: WIDTH];
        end
    end

    assign fifo_wdata = w_wdata;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized bench for fifo_wr_arb with a behavioural arbiter model.
// Follows FIFO_ARB_BURST_EN so the model matches the build.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BL = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           res = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic           fifo_full = 1'b0;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wdata;
    logic [1:0]     owner;

    int tests = 0;
    int fails = 0;

    int unsigned m_owner  = N - 1;
    int unsigned m_used   = 0;
    bit          m_inburst = 1'b0;

    fifo_wr_arb #(
        .WIDTH     (W),
        .NUM_REQ   (N),
        .BURST_LEN (BL)
    ) dut (
        .clk        (clk),
        .res        (res),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Current owner keeps the bus while it asks and has budget left.
    function automatic bit keeps_bus();
        return BE && m_inburst && req[m_owner] && (m_used < BL);
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g;
        int unsigned  i;
        g = '0;
        if (!res || fifo_full) return g;
        if (keeps_bus()) begin
            g[m_owner] = 1'b1;
            return g;
        end
        for (int k = 1; k <= N; k++) begin
            i = (m_owner + k) % N;
            if (req[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Model bookkeeping at each edge using the inputs seen at that edge.
    always @(posedge clk or negedge res) begin
        logic [N-1:0] e;
        if (!res) begin
            m_owner   = N - 1;
            m_used    = 0;
            m_inburst = 1'b0;
        end else begin
            e = exp_gnt();
            if (keeps_bus() && !fifo_full) begin
                m_used++;
            end else if (e != '0) begin
                for (int i = 0; i < N; i++)
                    if (e[i]) m_owner = i;
                m_used    = 1;
                m_inburst = (BL > 1);
            end else if (!fifo_full) begin
                m_inburst = 1'b0;
            end
        end
    end

    // Every cycle: outputs against the model.
    always @(negedge clk) begin
        logic [N-1:0] e;
        logic [W-1:0] d;
        e = exp_gnt();
        d = '0;
        for (int i = 0; i < N; i++)
            if (e[i]) d = req_data[i*W +: W];
        chk("gnt", 32'(gnt), 32'(e));
        chk("wr_en", 32'(fifo_wr_en), 32'(|e));
        chk("wdata", 32'(fifo_wdata), 32'(d));
        chk("owner", 32'(owner), 32'(m_owner));
    end

    task automatic hold_reset();
        @(posedge clk);
        #1;
        res       = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic step(input logic [N-1:0] r, input logic f,
                        input logic [N-1:0] eg, input string nm);
        @(posedge clk);
        #1;
        res       = 1'b1;
        req       = r;
        fifo_full = f;
        req_data  = $urandom;
        @(negedge clk);
        chk(nm, 32'(gnt), 32'(eg));
    endtask

    initial begin
        logic [N-1:0] sr[8];
        logic         sf[8];
        logic [N-1:0] se[8];
        int           rem[N];
        int           cnt;
        int           writes;
        int           ovf;
        bit           saw_full;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_owner", 32'(owner), 32'd3);

        // Pins the model: round-robin or burst sequence after reset.
        hold_reset();
        if (BE) begin
            for (int k = 0; k < 8; k++) begin
                sr[k] = 4'b0011;
                se[k] = (k < 4) ? 4'b0001 : 4'b0010;
            end
            for (int k = 0; k < 8; k++) step(sr[k], 1'b0, se[k], "burst_seq");
        end else begin
            se[0] = 4'b0001; se[1] = 4'b0010; se[2] = 4'b0100;
            se[3] = 4'b1000; se[4] = 4'b0001;
            for (int k = 0; k < 5; k++) step(4'b1111, 1'b0, se[k], "rr_seq");
        end

        // Full pulse after two grants, then exactly two more, then idle.
        hold_reset();
        sf[0] = 0; sf[1] = 0; sf[2] = 1; sf[3] = 1;
        sf[4] = 0; sf[5] = 0; sf[6] = 0;
        se[0] = 1; se[1] = 1; se[2] = 0; se[3] = 0;
        se[4] = 1; se[5] = 1; se[6] = 0;
        for (int k = 0; k < 7; k++)
            step((k < 6) ? 4'b0001 : 4'b0000, sf[k], se[k], "full_pulse");

        // Async reset mid-burst, then requester 0 wins first.
        hold_reset();
        step(4'b0011, 1'b0, 4'b0001, "pre_rst0");
        step(4'b0011, 1'b0, BE ? 4'b0001 : 4'b0010, "pre_rst1");
        @(posedge clk);
        #3;
        res = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_wr_en", 32'(fifo_wr_en), 32'd0);
        repeat (2) @(posedge clk);
        step(4'b1111, 1'b0, 4'b0001, "post_rst");

        // Attached to a 16-deep FIFO with no reads.
        hold_reset();
        for (int i = 0; i < N; i++) rem[i] = 8;
        cnt = 0; writes = 0; ovf = 0; saw_full = 0;
        for (int c = 0; c < 48; c++) begin
            @(posedge clk);
            #1;
            res = 1'b1;
            for (int i = 0; i < N; i++) req[i] = (rem[i] > 0);
            fifo_full = (cnt == 16);
            if (fifo_full) saw_full = 1;
            req_data = $urandom;
            @(negedge clk);
            if (fifo_wr_en) begin
                if (cnt == 16) ovf++;
                cnt++;
                writes++;
                for (int i = 0; i < N; i++)
                    if (gnt[i]) rem[i]--;
            end
        end
        chk("fifo_writes", 32'(writes), 32'd16);
        chk("fifo_full_seen", 32'(saw_full), 32'd1);
        chk("fifo_overflow", 32'(ovf), 32'd0);

        // Random traffic, checked every cycle by the compare process.
        hold_reset();
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            res       = ($urandom_range(0, 99) != 0);
            req       = N'($urandom);
            fifo_full = ($urandom_range(0, 4) == 0);
            req_data  = $urandom;
        end

        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the data width in bits and matching the FIFO wdata width.
REQ-002 The block SHALL have the parameter NUM_REQ, default 4, giving the number of write requesters (legal range 2..16).
REQ-003 The block SHALL have the parameter BURST_LEN, default 4, giving the maximum number of consecutive grants to one owner (legal range 1..16).
REQ-004 Port clk SHALL be a 1-bit input, the single clock; all state SHALL update on its rising edge.
REQ-005 Port res SHALL be a 1-bit input, the reset, asynchronous and active-low.
REQ-006 Port req SHALL be a NUM_REQ-bit input; bit i high means requester i has a word to write.
REQ-007 Port req_data SHALL be a NUM_REQ*WIDTH-bit input; slice [i*WIDTH +: WIDTH] carries requester i's data.
REQ-008 Port gnt SHALL be a NUM_REQ-bit output, one-hot or zero; bit i high means requester i's word is written this cycle.
REQ-009 Port fifo_full SHALL be a 1-bit input, the full flag of the sync FIFO.
REQ-010 Port fifo_wr_en SHALL be a 1-bit output, driving the FIFO wr_en.
REQ-011 Port fifo_wdata SHALL be a WIDTH-bit output, driving the FIFO wdata.
REQ-012 Port owner SHALL be a $clog2(NUM_REQ)-bit output giving the index of the last-granted requester.

Function
REQ-013 gnt SHALL be decoded combinationally from req, fifo_full and registered state; the transfer SHALL complete on the rising edge at which gnt[i] and req[i] are both high.
REQ-014 fifo_wr_en SHALL equal |gnt, and fifo_wdata SHALL equal the granted slice of req_data, or 0 when no grant is active.
REQ-015 gnt SHALL be all-zero whenever fifo_full is high; a write SHALL never be issued into a full FIFO.
REQ-016 In state IDLE, the grant SHALL go to the first requester with req high, searching from (owner+1) mod NUM_REQ upward with wrap-around.
REQ-017 On a grant from IDLE, owner SHALL be set to the granted index, the burst counter SHALL be set to 1, and the state SHALL move to BURST when BURST_LEN > 1.
REQ-018 In state BURST, the grant SHALL go to owner alone while req[owner] is high, fifo_full is low, and the burst counter is below BURST_LEN; each such grant SHALL increment the counter.
REQ-019 BURST SHALL return to IDLE in the same cycle, with round-robin arbitration then applied, when req[owner] is low or the counter equals BURST_LEN.
REQ-020 When fifo_full is high in BURST, no grant SHALL be issued; the state and counter SHALL hold, and the burst SHALL resume when full clears.
REQ-021 The burst counter SHALL be $clog2(BURST_LEN+1) bits wide and SHALL never wrap.

Reset
REQ-022 While res is low: state SHALL be IDLE, owner SHALL be NUM_REQ-1 (so requester 0 wins first), the counter SHALL be 0, and gnt, fifo_wr_en and fifo_wdata SHALL be 0.
REQ-023 Assertion of res mid-burst SHALL abort the burst immediately, with no partial grant visible after the reset edge.

Configuration
REQ-024 With macro FIFO_ARB_BURST_EN defined, the BURST state and counter SHALL be compiled in as specified above.
REQ-025 Without FIFO_ARB_BURST_EN, the BURST state and counter SHALL be absent, every grant SHALL be pure round-robin (one word per owner turn), and BURST_LEN SHALL be ignored.

Structure
REQ-026 A shared package fifo_arb_pkg SHALL hold the FSM state encoding (IDLE=0, BURST=1) and the default WIDTH and NUM_REQ constants.
REQ-027 The round-robin priority search SHALL be a sub-module rr_pick (inputs: req vector and start index; outputs: one-hot grant and valid).

Verification
REQ-028 Reset release, req=4'b1111, full=0, macro off: grants SHALL be 0,1,2,3,0 on consecutive cycles, with fifo_wdata matching each slice.
REQ-029 Macro on, BURST_LEN=4, req=4'b0011 held: gnt[0] SHALL be high for 4 cycles, then gnt[1] for 4 cycles.
REQ-030 Macro on, req0 held, fifo_full pulsed high for 2 cycles after the 2nd grant: gnt SHALL be 0 for those 2 cycles, then req0 SHALL receive exactly 2 more grants.
REQ-031 With the arbiter connected to a 16-deep sync FIFO, 4 requesters each writing 8 words and no reads: exactly 16 writes SHALL occur, full SHALL assert, and overflow SHALL never assert.
REQ-032 res driven low asynchronously between clock edges mid-burst: gnt and fifo_wr_en SHALL drop to 0 immediately, and after release requester 0 SHALL win first.
